// File: rtl/game_pkg.sv
// Shared game-side types: life-cycle state encoding, lives width and the
// ship/lives flag decode used by lives_ctl and the lives draw stage.
package game_pkg;

  localparam int LIVES_W = 4;
  localparam int FRAME_W = 8;

  localparam logic [1:0] ALIVE     = 2'd0;
  localparam logic [1:0] EXPLODE   = 2'd1;
  localparam logic [1:0] INVULN    = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  typedef enum logic [1:0] {
    ST_ALIVE     = ALIVE,
    ST_EXPLODE   = EXPLODE,
    ST_INVULN    = INVULN,
    ST_GAME_OVER = GAME_OVER
  } life_state_t;

  typedef struct packed {
    logic ship_enable;
    logic ship_visible;
    logic explode;
    logic invulnerable;
    logic game_over;
  } ship_flags_t;

  // Per-state output flags; blink_vis only matters while invulnerable.
  function automatic ship_flags_t state_flags(life_state_t st, logic blink_vis);
    ship_flags_t f;
    f.ship_enable  = 1'b1;
    f.ship_visible = 1'b1;
    f.explode      = 1'b0;
    f.invulnerable = 1'b0;
    f.game_over    = 1'b0;
    case (st)
      ST_EXPLODE: begin
        f.ship_enable  = 1'b0;
        f.ship_visible = 1'b0;
        f.explode      = 1'b1;
        f.invulnerable = 1'b1;
      end
      ST_INVULN: begin
        f.ship_visible = blink_vis;
        f.invulnerable = 1'b1;
      end
      ST_GAME_OVER: begin
        f.ship_enable  = 1'b0;
        f.ship_visible = 1'b0;
        f.invulnerable = 1'b1;
        f.game_over    = 1'b1;
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lives_ctl_if.sv
// Collision/frame inputs and ship/lives status outputs of lives_ctl.
interface lives_ctl_if;

  logic                           vsync_in;
  logic                           hit;
  logic                           new_game;
  logic [game_pkg::LIVES_W-1:0]   dead_count;
  logic                           ship_enable;
  logic                           ship_visible;
  logic                           explode;
  logic                           invulnerable;
  logic                           game_over;
  logic                           respawn;

  modport master (
    output vsync_in, hit, new_game,
    input  dead_count, ship_enable, ship_visible, explode,
           invulnerable, game_over, respawn
  );

  modport slave (
    input  vsync_in, hit, new_game,
    output dead_count, ship_enable, ship_visible, explode,
           invulnerable, game_over, respawn
  );

endinterface

// File: rtl/frame_tick.sv
// Rising-edge detector on vsync: one-cycle tick in the first cycle vsync is
// seen high. Reusable by any per-frame block.
module frame_tick (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_q_reg;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q_reg <= 1'b0;
    end else begin
      vsync_q_reg <= vsync_in;
    end
  end

  assign tick = vsync_in & ~vsync_q_reg;

endmodule

// File: rtl/lives_ctl.sv
// Player life-cycle sequencer: ALIVE -> EXPLODE -> INVULN/GAME_OVER, paced by
// frame ticks. Define LIVES_CTL_BLINK_EN to blink the ship while invulnerable.
module lives_ctl
  import game_pkg::*;
#(
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 30,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_HALF     = 8
) (
  input  logic        pclk,
  input  logic        rst,
  lives_ctl_if.slave  bus
);

  if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
    $error("lives_ctl: LIVES must be 1..15");
  end
  if (EXPLODE_FRAMES < 1 || EXPLODE_FRAMES > 255) begin : g_bad_explode
    $error("lives_ctl: EXPLODE_FRAMES must be 1..255");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
    $error("lives_ctl: INVULN_FRAMES must be 1..255");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_bad_blink
    $error("lives_ctl: BLINK_HALF must be 1..255");
  end

  localparam logic [LIVES_W-1:0] LIVES_MAX    = LIVES_W'(LIVES);
  localparam logic [FRAME_W-1:0] EXPLODE_LAST = FRAME_W'(EXPLODE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] INVULN_LAST  = FRAME_W'(INVULN_FRAMES - 1);

  logic                tick;
  life_state_t         state_reg, state_next;
  logic [FRAME_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [LIVES_W-1:0]  dead_count_reg, dead_count_next;
  logic                respawn_reg, respawn_next;
  logic                blink_vis_next;
  ship_flags_t         flags_reg, flags_next;

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (bus.vsync_in),
    .tick     (tick)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg      <= ST_ALIVE;
      frame_cnt_reg  <= '0;
      dead_count_reg <= '0;
      respawn_reg    <= 1'b0;
      flags_reg      <= state_flags(ST_ALIVE, 1'b1);
    end else begin
      state_reg      <= state_next;
      frame_cnt_reg  <= frame_cnt_next;
      dead_count_reg <= dead_count_next;
      respawn_reg    <= respawn_next;
      flags_reg      <= flags_next;
    end
  end

  // new_game outranks both hit and the frame tick.
  always_comb begin
    state_next      = state_reg;
    frame_cnt_next  = frame_cnt_reg + (tick ? 8'd1 : 8'd0);
    dead_count_next = dead_count_reg;
    respawn_next    = 1'b0;
    if (bus.new_game) begin
      state_next      = ST_ALIVE;
      frame_cnt_next  = '0;
      dead_count_next = '0;
    end else begin
      case (state_reg)
        ST_ALIVE: begin
          if (bus.hit && (dead_count_reg < LIVES_MAX)) begin
            dead_count_next = dead_count_reg + 4'd1;
            state_next      = ST_EXPLODE;
            frame_cnt_next  = '0;
          end
        end
        ST_EXPLODE: begin
          if (tick && (frame_cnt_reg == EXPLODE_LAST)) begin
            frame_cnt_next = '0;
            if (dead_count_reg == LIVES_MAX) begin
              state_next = ST_GAME_OVER;
            end else begin
              state_next   = ST_INVULN;
              respawn_next = 1'b1;
            end
          end
        end
        ST_INVULN: begin
          if (tick && (frame_cnt_reg == INVULN_LAST)) begin
            state_next     = ST_ALIVE;
            frame_cnt_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LIVES_CTL_BLINK_EN
  localparam logic [FRAME_W-1:0] BLINK_LAST = FRAME_W'(BLINK_HALF - 1);

  logic [FRAME_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               blink_vis_reg;

  // Phase starts invisible on INVULN entry and flips every BLINK_HALF ticks.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    blink_vis_next = blink_vis_reg;
    if ((state_next == ST_INVULN) && (state_reg != ST_INVULN)) begin
      blink_cnt_next = '0;
      blink_vis_next = 1'b0;
    end else if ((state_reg == ST_INVULN) && tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_vis_next = ~blink_vis_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      blink_vis_reg <= 1'b1;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      blink_vis_reg <= blink_vis_next;
    end
  end
`else
  assign blink_vis_next = 1'b1;
`endif

  assign flags_next = state_flags(state_next, blink_vis_next);

  assign bus.dead_count   = dead_count_reg;
  assign bus.ship_enable  = flags_reg.ship_enable;
  assign bus.ship_visible = flags_reg.ship_visible;
  assign bus.explode      = flags_reg.explode;
  assign bus.invulnerable = flags_reg.invulnerable;
  assign bus.game_over    = flags_reg.game_over;
  assign bus.respawn      = respawn_reg;

endmodule

// File: tb/tb_lives_ctl.sv
// Bench for lives_ctl: directed frames/hits, a per-cycle behavioural model
// compare, and hand-computed spot checks at key points of the game.
module tb_lives_ctl;

  localparam int LIVES          = 3;
  localparam int EXPLODE_FRAMES = 2;
  localparam int INVULN_FRAMES  = 4;
  localparam int BLINK_HALF     = 1;

`ifdef LIVES_CTL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam int M_ALIVE = 0, M_EXPLODE = 1, M_INVULN = 2, M_OVER = 3;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lives_ctl_if bus ();

  lives_ctl #(
    .LIVES          (LIVES),
    .EXPLODE_FRAMES (EXPLODE_FRAMES),
    .INVULN_FRAMES  (INVULN_FRAMES),
    .BLINK_HALF     (BLINK_HALF)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 pclk = ~pclk;

  // Behavioural model: mode, ticks seen since entering it, lives lost.
  int   m_mode  = M_ALIVE;
  int   m_ticks = 0;
  int   m_dead  = 0;
  bit   m_prev  = 1'b0;
  bit   m_resp  = 1'b0;

  task automatic model_step();
    bit tk;
    if (rst) begin
      m_mode = M_ALIVE; m_ticks = 0; m_dead = 0; m_prev = 1'b0; m_resp = 1'b0;
      return;
    end
    tk     = bus.vsync_in && !m_prev;
    m_prev = bus.vsync_in;
    m_resp = 1'b0;
    if (bus.new_game) begin
      m_mode = M_ALIVE; m_ticks = 0; m_dead = 0;
    end else if (m_mode == M_ALIVE && bus.hit && m_dead < LIVES) begin
      m_dead++; m_mode = M_EXPLODE; m_ticks = 0;
    end else if (tk) begin
      m_ticks++;
      if (m_mode == M_EXPLODE && m_ticks == EXPLODE_FRAMES) begin
        m_ticks = 0;
        m_mode  = (m_dead == LIVES) ? M_OVER : M_INVULN;
        m_resp  = (m_mode == M_INVULN);
      end else if (m_mode == M_INVULN && m_ticks == INVULN_FRAMES) begin
        m_ticks = 0;
        m_mode  = M_ALIVE;
      end
    end
  endtask

  // {dead_count, enable, visible, explode, invulnerable, game_over, respawn}
  function automatic logic [9:0] model_vec();
    bit en, vis, ex, inv, go;
    en  = (m_mode == M_ALIVE) || (m_mode == M_INVULN);
    ex  = (m_mode == M_EXPLODE);
    inv = (m_mode != M_ALIVE);
    go  = (m_mode == M_OVER);
    if (m_mode == M_INVULN) vis = BLINK ? (((m_ticks / BLINK_HALF) % 2) == 1) : 1'b1;
    else                    vis = (m_mode == M_ALIVE);
    return {4'(m_dead), en, vis, ex, inv, go, m_resp};
  endfunction

  initial begin
    logic [9:0] got, want;
    forever begin
      @(posedge pclk);
      model_step();
      #1;
      got  = {bus.dead_count, bus.ship_enable, bus.ship_visible, bus.explode,
              bus.invulnerable, bus.game_over, bus.respawn};
      want = model_vec();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL model_cycle t=%0t got=%b want=%b", $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic frame();
    @(negedge pclk) bus.vsync_in = 1'b1;
    @(negedge pclk);
    @(negedge pclk) bus.vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic pulse_hit();
    @(negedge pclk) bus.hit = 1'b1;
    @(negedge pclk) bus.hit = 1'b0;
  endtask

  initial begin
    bus.vsync_in = 1'b0; bus.hit = 1'b0; bus.new_game = 1'b0;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    chk("rst_dead", bus.dead_count, 4'd0);
    chk("rst_enable", {3'd0, bus.ship_enable}, 4'd1);
    chk("rst_visible", {3'd0, bus.ship_visible}, 4'd1);
    chk("rst_explode", {3'd0, bus.explode}, 4'd0);
    chk("rst_invuln", {3'd0, bus.invulnerable}, 4'd0);
    chk("rst_over", {3'd0, bus.game_over}, 4'd0);
    chk("rst_respawn", {3'd0, bus.respawn}, 4'd0);

    repeat (10) frame();
    chk("idle_dead", bus.dead_count, 4'd0);
    chk("idle_visible", {3'd0, bus.ship_visible}, 4'd1);

    pulse_hit();
    chk("hit1_dead", bus.dead_count, 4'd1);
    chk("hit1_explode", {3'd0, bus.explode}, 4'd1);
    chk("hit1_enable", {3'd0, bus.ship_enable}, 4'd0);
    pulse_hit();
    chk("hit_in_explode_dead", bus.dead_count, 4'd1);
    frame();
    chk("explode_after_1tick", {3'd0, bus.explode}, 4'd1);

    @(negedge pclk) bus.vsync_in = 1'b1;
    @(negedge pclk);
    chk("respawn_pulse", {3'd0, bus.respawn}, 4'd1);
    chk("respawn_invuln", {3'd0, bus.invulnerable}, 4'd1);
    chk("respawn_explode", {3'd0, bus.explode}, 4'd0);
    chk("invuln_vis0", {3'd0, bus.ship_visible}, BLINK ? 4'd0 : 4'd1);
    @(negedge pclk) bus.vsync_in = 1'b0;
    chk("respawn_single", {3'd0, bus.respawn}, 4'd0);
    @(negedge pclk);

    pulse_hit();
    chk("hit_in_invuln_dead", bus.dead_count, 4'd1);
    frame();
    chk("invuln_vis1", {3'd0, bus.ship_visible}, 4'd1);
    frame();
    chk("invuln_vis2", {3'd0, bus.ship_visible}, BLINK ? 4'd0 : 4'd1);
    frame();
    chk("invuln_vis3", {3'd0, bus.ship_visible}, 4'd1);
    chk("invuln_still", {3'd0, bus.invulnerable}, 4'd1);
    frame();
    chk("alive_invuln", {3'd0, bus.invulnerable}, 4'd0);
    chk("alive_enable", {3'd0, bus.ship_enable}, 4'd1);

    // Hit on the same cycle as a frame tick: EXPLODE starts counting from 0.
    @(negedge pclk) begin bus.hit = 1'b1; bus.vsync_in = 1'b1; end
    @(negedge pclk) bus.hit = 1'b0;
    chk("hit2_dead", bus.dead_count, 4'd2);
    @(negedge pclk) bus.vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
    frame();
    chk("hit_tick_explode", {3'd0, bus.explode}, 4'd1);
    frame();
    chk("hit2_invuln", {3'd0, bus.invulnerable}, 4'd1);
    chk("hit2_explode", {3'd0, bus.explode}, 4'd0);
    repeat (4) frame();
    chk("hit2_alive", {3'd0, bus.invulnerable}, 4'd0);

    pulse_hit();
    chk("hit3_dead", bus.dead_count, 4'd3);
    frame();
    frame();
    chk("over_flag", {3'd0, bus.game_over}, 4'd1);
    chk("over_dead", bus.dead_count, 4'd3);
    chk("over_enable", {3'd0, bus.ship_enable}, 4'd0);
    chk("over_respawn", {3'd0, bus.respawn}, 4'd0);
    pulse_hit();
    chk("over_hit_dead", bus.dead_count, 4'd3);
    repeat (3) frame();
    chk("over_hold", {3'd0, bus.game_over}, 4'd1);

    @(negedge pclk) bus.new_game = 1'b1;
    @(negedge pclk) bus.new_game = 1'b0;
    chk("ng_dead", bus.dead_count, 4'd0);
    chk("ng_over", {3'd0, bus.game_over}, 4'd0);
    chk("ng_enable", {3'd0, bus.ship_enable}, 4'd1);

    @(negedge pclk) begin bus.new_game = 1'b1; bus.hit = 1'b1; end
    @(negedge pclk) begin bus.new_game = 1'b0; bus.hit = 1'b0; end
    chk("ng_hit_dead", bus.dead_count, 4'd0);
    chk("ng_hit_explode", {3'd0, bus.explode}, 4'd0);

    pulse_hit();
    chk("pre_rst_explode", {3'd0, bus.explode}, 4'd1);
    @(negedge pclk) rst = 1'b1;
    @(negedge pclk) rst = 1'b0;
    chk("midrst_dead", bus.dead_count, 4'd0);
    chk("midrst_explode", {3'd0, bus.explode}, 4'd0);
    chk("midrst_enable", {3'd0, bus.ship_enable}, 4'd1);
    chk("midrst_invuln", {3'd0, bus.invulnerable}, 4'd0);
    frame();
    chk("post_rst_alive", {3'd0, bus.explode}, 4'd0);

    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
